alu_result_stage: RTL and testbench

Registered output stage directly downstream of the generated 8-bit ALUs. It captures each ALU result with its opcode and flags through a valid/ready handshake, buffers up to two entries so backpressure never stalls the ALU mid-result, and normalises the flag vector. It also keeps a wrapping operation counter and, when enabled, sticky carry and overflow status for software polling.

---
 rtl/alu_result_stage_if.sv | 32 +++
 rtl/alu_result_stage.sv | 136 +++++++++++++
 tb/tb_alu_result_stage.sv | 224 ++++++++++++++++++++++
 3 files changed

// File: rtl/alu_result_stage_if.sv
// Handshake bundle between the ALU, alu_result_stage and its consumer.
// The stage sits on the slave modport; the ALU/consumer side uses master.
interface alu_result_stage_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       opcode;
    logic [WIDTH-1:0] result;
    logic             carryFlag;
    logic             overFlowFlag;
    logic             zeroFlag;
    logic             signFlag;

    logic             out_valid;
    logic             out_ready;
    logic [3:0]       out_opcode;
    logic [WIDTH-1:0] out_result;
    logic [3:0]       out_flags;

    modport slave (
        input  in_valid, opcode, result, carryFlag, overFlowFlag, zeroFlag, signFlag,
        input  out_ready,
        output in_ready, out_valid, out_opcode, out_result, out_flags
    );

    modport master (
        output in_valid, opcode, result, carryFlag, overFlowFlag, zeroFlag, signFlag,
        output out_ready,
        input  in_ready, out_valid, out_opcode, out_result, out_flags
    );
endinterface

// File: rtl/alu_result_stage.sv
// Two-entry registered output stage for the 8-bit ALUs with flag normalisation,
// op counter and optional sticky carry/overflow status (ALU_RESULT_STICKY_EN).
module alu_result_stage #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    alu_result_stage_if.slave bus,
    output logic [CNT_W-1:0]  ops_count,
    input  logic              sticky_clr,
    output logic [1:0]        sticky_flags
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } state_e;

    typedef struct packed {
        logic [3:0]       opcode;
        logic [WIDTH-1:0] result;
        logic [3:0]       flags;
    } entry_t;

    state_e           state_q, state_d;
    logic             in_ready_q, in_ready_d;
    logic             wr_ptr_q, rd_ptr_q;
    entry_t           mem_q [2];
    logic [CNT_W-1:0] ops_count_q;

    logic   push, pop;
    logic   arith_op;
    logic   norm_carry, norm_ovf;
    entry_t in_entry;
    entry_t head;

    assign push = bus.in_valid & in_ready_q;
    assign pop  = (state_q != EMPTY) & bus.out_ready;

    // Only ADD/SUB produce meaningful carry/overflow; zero and sign are rebuilt from the result.
    always_comb begin
        arith_op          = (bus.opcode == 4'd4) || (bus.opcode == 4'd6);
        norm_carry        = arith_op & bus.carryFlag;
        norm_ovf          = arith_op & bus.overFlowFlag;
        in_entry          = '0;
        in_entry.opcode   = bus.opcode;
        in_entry.result   = bus.result;
        in_entry.flags    = {bus.result[WIDTH-1], norm_ovf, (bus.result == '0), norm_carry};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= EMPTY;
            in_ready_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            EMPTY: if (push) state_d = ONE;
            ONE: begin
                if (push && !pop)      state_d = FULL;
                else if (!push && pop) state_d = EMPTY;
            end
            FULL:    if (pop) state_d = ONE;
            default: state_d = EMPTY;
        endcase
        // Registered ready: a pop from FULL frees the slot only on the next cycle.
        in_ready_d = (state_d != FULL);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < 2; i++) begin
                mem_q[i] <= '0;
            end
            wr_ptr_q    <= 1'b0;
            rd_ptr_q    <= 1'b0;
            ops_count_q <= '0;
        end else begin
            if (push) begin
                mem_q[wr_ptr_q] <= in_entry;
                wr_ptr_q        <= ~wr_ptr_q;
                ops_count_q     <= ops_count_q + CNT_W'(1);
            end
            if (pop) begin
                rd_ptr_q <= ~rd_ptr_q;
            end
        end
    end

    assign head           = mem_q[rd_ptr_q];
    assign bus.in_ready   = in_ready_q;
    assign bus.out_valid  = (state_q != EMPTY);
    assign bus.out_opcode = head.opcode;
    assign bus.out_result = head.result;
    assign bus.out_flags  = head.flags;
    assign ops_count      = ops_count_q;

`ifdef ALU_RESULT_STICKY_EN
    logic [1:0] sticky_q, sticky_d;

    // Clear first, then OR in the accepted flags so a same-cycle set wins.
    always_comb begin
        sticky_d = sticky_clr ? 2'b00 : sticky_q;
        if (push) begin
            sticky_d = sticky_d | {norm_ovf, norm_carry};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sticky_q <= '0;
        end else begin
            sticky_q <= sticky_d;
        end
    end

    assign sticky_flags = sticky_q;

    logic unused_inputs;
    assign unused_inputs = ^{bus.zeroFlag, bus.signFlag};
`else
    assign sticky_flags = '0;

    logic unused_inputs;
    assign unused_inputs = ^{bus.zeroFlag, bus.signFlag, sticky_clr};
`endif

endmodule

// File: tb/tb_alu_result_stage.sv
// Scoreboard bench for alu_result_stage: driver pushes hand-computed expected
// entries, an independent monitor pops and compares on every output transfer.
module tb_alu_result_stage;
    localparam int unsigned WIDTH = 8;
    localparam int unsigned CNT_W = 8;
`ifdef ALU_RESULT_STICKY_EN
    localparam bit STK = 1'b1;
`else
    localparam bit STK = 1'b0;
`endif

    logic             clk;
    logic             rst_n;
    logic             sticky_clr;
    logic [CNT_W-1:0] ops_count;
    logic [1:0]       sticky_flags;

    int tests_run;
    int errors;
    int acc_cnt;
    logic [15:0] exp_q [$];

    alu_result_stage_if #(.WIDTH(WIDTH)) ifc ();

    alu_result_stage #(
        .WIDTH(WIDTH),
        .CNT_W(CNT_W)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .bus         (ifc.slave),
        .ops_count   (ops_count),
        .sticky_clr  (sticky_clr),
        .sticky_flags(sticky_flags)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests_run++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: one comparison per output transfer, sampled mid-low-phase.
    always begin
        @(negedge clk);
        #1;
        if (rst_n && ifc.out_valid && ifc.out_ready) begin
            if (exp_q.size() == 0) begin
                tests_run++;
                errors++;
                $display("FAIL unexpected_output: got 0x%0h expected none",
                         {ifc.out_opcode, ifc.out_result, ifc.out_flags});
            end else begin
                check("out_entry", {16'h0, ifc.out_opcode, ifc.out_result, ifc.out_flags},
                      {16'h0, exp_q[0]});
                void'(exp_q.pop_front());
            end
        end
    end

    // Called just after a negedge; returns just after the negedge following acceptance.
    task automatic drive(input logic [3:0] op, input logic [7:0] res, input logic c,
                         input logic o, input logic z, input logic [3:0] exp_flags);
        bit accepted;
        accepted         = 1'b0;
        ifc.opcode       = op;
        ifc.result       = res;
        ifc.carryFlag    = c;
        ifc.overFlowFlag = o;
        ifc.zeroFlag     = z;
        ifc.signFlag     = res[7];
        ifc.in_valid     = 1'b1;
        for (int n = 0; n < 50 && !accepted; n++) begin
            if (ifc.in_ready) begin
                exp_q.push_back({op, res, exp_flags});
                acc_cnt++;
                accepted = 1'b1;
            end
            @(posedge clk);
            @(negedge clk);
        end
        ifc.in_valid = 1'b0;
        if (!accepted) begin
            tests_run++;
            errors++;
            $display("FAIL drive_timeout: got in_ready 0 expected 1");
        end
    endtask

    task automatic drain();
        for (int n = 0; n < 20 && exp_q.size() != 0; n++) @(negedge clk);
        #2;
        check("drain_empty", exp_q.size(), 0);
    endtask

    initial begin
        tests_run        = 0;
        errors           = 0;
        acc_cnt          = 0;
        rst_n            = 1'b0;
        sticky_clr       = 1'b0;
        ifc.in_valid     = 1'b1;
        ifc.opcode       = 4'd4;
        ifc.result       = 8'h05;
        ifc.carryFlag    = 1'b1;
        ifc.overFlowFlag = 1'b1;
        ifc.zeroFlag     = 1'b0;
        ifc.signFlag     = 1'b0;
        ifc.out_ready    = 1'b1;

        // Reset with input offered
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", ifc.in_ready, 0);
        check("rst_out_valid", ifc.out_valid, 0);
        check("rst_out_all", {ifc.out_opcode, ifc.out_result, ifc.out_flags}, 0);
        check("rst_ops", ops_count, 0);
        check("rst_sticky", sticky_flags, 0);
        rst_n = 1'b1;
        @(posedge clk);
        @(negedge clk);
        check("rel_in_ready", ifc.in_ready, 1);
        check("rel_ops", ops_count, 0);
        ifc.in_valid = 1'b0;
        @(negedge clk);
        check("rel_ops_idle", ops_count, 0);

        // Single ADD: zero recomputed, carry kept; 1-cycle latency, no lookahead
        check("add_pre_valid", ifc.out_valid, 0);
        drive(4'd4, 8'h00, 1'b1, 1'b0, 1'b0, 4'b0011);
        check("add_latency_valid", ifc.out_valid, 1);
        check("add_ops", ops_count, 1);
        check("add_sticky", sticky_flags, STK ? 2'b01 : 2'b00);

        // XOR: carry/overflow masked, sign set, zeroFlag input ignored
        drive(4'd7, 8'h80, 1'b1, 1'b1, 1'b1, 4'b1000);
        check("xor_sticky", sticky_flags, STK ? 2'b01 : 2'b00);
        drain();

        // Backpressure and ordering
        ifc.out_ready = 1'b0;
        drive(4'd1, 8'h11, 1'b0, 1'b0, 1'b0, 4'b0000);
        check("bp_ready_one", ifc.in_ready, 1);
        drive(4'd2, 8'h22, 1'b1, 1'b0, 1'b0, 4'b0000);
        check("bp_ready_full", ifc.in_ready, 0);
        ifc.opcode   = 4'd3;
        ifc.result   = 8'h33;
        ifc.in_valid = 1'b1;
        repeat (3) @(negedge clk);
        ifc.in_valid = 1'b0;
        check("bp_refused_ops", ops_count, 4);
        check("bp_hold_result", ifc.out_result, 8'h11);
        check("bp_still_full", ifc.in_ready, 0);
        ifc.out_ready = 1'b1;
        @(negedge clk);
        check("bp_ready_after_pop", ifc.in_ready, 1);
        drain();

        // Streaming in ONE: push and pop each cycle, never fills
        for (int i = 1; i <= 5; i++) begin
            drive(4'd5, 8'(i), 1'b1, 1'b1, 1'b0, 4'b0000);
            check("stream_ready", ifc.in_ready, 1);
        end
        check("stream_ops", ops_count, 9);
        drain();

        // Sticky status
        sticky_clr = 1'b1;
        @(negedge clk);
        sticky_clr = 1'b0;
        check("stk_cleared", sticky_flags, 0);
        drive(4'd6, 8'h01, 1'b0, 1'b1, 1'b0, 4'b0100);
        check("stk_sub_ovf", sticky_flags, STK ? 2'b10 : 2'b00);
        sticky_clr = 1'b1;
        drive(4'd4, 8'h02, 1'b1, 1'b0, 1'b0, 4'b0001);
        sticky_clr = 1'b0;
        check("stk_set_wins", sticky_flags, STK ? 2'b01 : 2'b00);
        drive(4'd6, 8'hF0, 1'b1, 1'b1, 1'b0, 4'b1101);
        check("stk_both", sticky_flags, STK ? 2'b11 : 2'b00);
        drain();

        // Counter wrap at 2^CNT_W
        while ((acc_cnt % 256) != 255) begin
            logic [7:0] r;
            r = 8'(acc_cnt * 7);
            drive(4'd0, r, 1'b1, 1'b1, 1'b0, {r[7], 1'b0, (r == 8'h00), 1'b0});
        end
        check("wrap_max", ops_count, 255);
        drive(4'd9, 8'h7F, 1'b0, 1'b0, 1'b0, 4'b0000);
        check("wrap_zero", ops_count, 0);
        drain();

        // Reset while holding entries discards them
        ifc.out_ready = 1'b0;
        drive(4'd4, 8'hAA, 1'b0, 1'b0, 1'b0, 4'b1000);
        drive(4'd4, 8'hBB, 1'b0, 1'b0, 1'b0, 4'b1000);
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_valid", ifc.out_valid, 0);
        check("midrst_ready", ifc.in_ready, 0);
        check("midrst_ops", ops_count, 0);
        check("midrst_sticky", sticky_flags, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ifc.out_ready = 1'b1;
        repeat (3) @(negedge clk);
        check("midrst_no_flush", ifc.out_valid, 0);

        $display("[TB] %0d tests run, %0d failed", tests_run, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1, "timeout");
    end
endmodule
